// File: rtl/acc_pkg.sv
// Shared definitions for the integrate-and-dump accumulator: op encodings and
// the sample-counter width helper.
package acc_pkg;

  localparam logic ACC_OP_ADD = 1'b0;
  localparam logic ACC_OP_SUB = 1'b1;

  // Width that can hold every value 0..n.
  function automatic int acc_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/acc_addsat.sv
// Combinational ACC_W-bit add/subtract with carry/borrow detection.
// Build option: define ACC_SAT_EN to clamp out-of-range results instead of wrapping.
module acc_addsat
  import acc_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] operand,
  input  logic [ACC_W-1:0] sample,
  input  logic             op,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  logic [ACC_W:0] wide;

  // NOTE: every output of this block is assigned on every path, so no latch is inferred.
  always_comb begin
    if (op == ACC_OP_SUB) begin
      wide = {1'b0, operand} - {1'b0, sample};
    end else begin
      wide = {1'b0, operand} + {1'b0, sample};
    end
    // The extra top bit is the carry for an add and the borrow for a subtract.
    ovf = wide[ACC_W];
`ifdef ACC_SAT_EN
    if (!ovf) begin
      result = wide[ACC_W-1:0];
    end else if (op == ACC_OP_SUB) begin
      result = '0;
    end else begin
      result = '1;
    end
`else
    result = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/acc_dump.sv
// Integrate-and-dump accumulator: sums N accepted samples, emits the window total
// on a one-cycle strobe, then restarts. Build option ACC_SAT_EN selects clamping.
module acc_dump
  import acc_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int ACC_W = 8,
  parameter int N     = 10,
  localparam int CNT_W = acc_cnt_w(N)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in,
  input  logic             sub,
  output logic [ACC_W-1:0] a,
  output logic [CNT_W-1:0] count,
  output logic             dump_valid,
  output logic [ACC_W-1:0] dump_data,
  output logic             dump_ovf
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [ACC_W-1:0] nxt;
  logic             step_ovf;
  logic             ovf;

  acc_addsat #(
    .ACC_W (ACC_W)
  ) u_addsat (
    .operand (a),
    .sample  (ACC_W'(in)),
    .op      (sub),
    .result  (nxt),
    .ovf     (step_ovf)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      a          <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_ovf   <= 1'b0;
    end else begin
      dump_valid <= 1'b0;
      if (in_valid) begin
        if (count == LAST) begin
          // Window complete: publish the total including this sample and restart.
          dump_data  <= nxt;
          dump_ovf   <= ovf | step_ovf;
          dump_valid <= 1'b1;
          a          <= '0;
          count      <= '0;
          ovf        <= 1'b0;
        end else begin
          a     <= nxt;
          count <= count + CNT_W'(1);
          ovf   <= ovf | step_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_dump.sv
// Self-checking bench for acc_dump: N=10, N=20 and N=1 instances share stimulus
// and are checked against an integer window-sum model plus directed vectors.
module tb_acc_dump;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] din = '0;
  logic       sub = 1'b0;

  logic [7:0] a10, dd10, a20, dd20, a1, dd1;
  logic [3:0] cnt10;
  logic [4:0] cnt20;
  logic [0:0] cnt1;
  logic       dv10, dovf10, dv20, dovf20, dv1, dovf1;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  acc_dump #(.IN_W(4), .ACC_W(8), .N(10)) u_n10 (
    .clk(clk), .clear_n(clear_n), .in_valid(in_valid), .in(din), .sub(sub),
    .a(a10), .count(cnt10), .dump_valid(dv10), .dump_data(dd10), .dump_ovf(dovf10));

  acc_dump #(.IN_W(4), .ACC_W(8), .N(20)) u_n20 (
    .clk(clk), .clear_n(clear_n), .in_valid(in_valid), .in(din), .sub(sub),
    .a(a20), .count(cnt20), .dump_valid(dv20), .dump_data(dd20), .dump_ovf(dovf20));

  acc_dump #(.IN_W(4), .ACC_W(8), .N(1)) u_n1 (
    .clk(clk), .clear_n(clear_n), .in_valid(in_valid), .in(din), .sub(sub),
    .a(a1), .count(cnt1), .dump_valid(dv1), .dump_data(dd1), .dump_ovf(dovf1));

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: window sum as a plain integer, folded back into 8 bits
  // by wrapping or clamping whenever it leaves 0..255.
  int nval[3] = '{10, 20, 1};
  int m_a[3], m_cnt[3], m_ovf[3], m_dv[3], m_dd[3], m_dovf[3];

  task automatic model_step(input bit c, input bit v, input int x, input bit s);
    int t;
    bit o;
    for (int i = 0; i < 3; i++) begin
      if (!c) begin
        m_a[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
        m_dv[i] = 0; m_dd[i] = 0; m_dovf[i] = 0;
      end else begin
        m_dv[i] = 0;
        if (v) begin
          t = s ? m_a[i] - x : m_a[i] + x;
          o = (t < 0) || (t > 255);
          if (o) t = SAT ? ((t < 0) ? 0 : 255) : ((t % 256) + 256) % 256;
          m_ovf[i] = m_ovf[i] | int'(o);
          m_cnt[i] = m_cnt[i] + 1;
          if (m_cnt[i] == nval[i]) begin
            m_dd[i] = t; m_dovf[i] = m_ovf[i]; m_dv[i] = 1;
            m_a[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
          end else begin
            m_a[i] = t;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("n10.a", int'(a10), m_a[0]);
    check("n10.count", int'(cnt10), m_cnt[0]);
    check("n10.dump_valid", int'(dv10), m_dv[0]);
    check("n10.dump_data", int'(dd10), m_dd[0]);
    check("n10.dump_ovf", int'(dovf10), m_dovf[0]);
    check("n20.a", int'(a20), m_a[1]);
    check("n20.count", int'(cnt20), m_cnt[1]);
    check("n20.dump_valid", int'(dv20), m_dv[1]);
    check("n20.dump_data", int'(dd20), m_dd[1]);
    check("n20.dump_ovf", int'(dovf20), m_dovf[1]);
    check("n1.a", int'(a1), m_a[2]);
    check("n1.count", int'(cnt1), m_cnt[2]);
    check("n1.dump_valid", int'(dv1), m_dv[2]);
    check("n1.dump_data", int'(dd1), m_dd[2]);
    check("n1.dump_ovf", int'(dovf1), m_dovf[2]);
  endtask

  // One clock: drive inputs, advance the model, sample 1 ns after the edge.
  task automatic cycle(input bit c, input bit v, input int x, input bit s);
    clear_n = c; in_valid = v; din = 4'(x); sub = s;
    model_step(c, v, x, s);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  typedef struct {
    bit v;
    int x;
    int ea;
    int ecnt;
    bit edv;
    int edd;
    bit eovf;
  } vec_t;

  vec_t tbl[11];

  initial begin
    for (int k = 1; k <= 10; k++) begin
      tbl[k-1] = '{v: 1'b1, x: k, ea: (k < 10) ? k * (k + 1) / 2 : 0,
                   ecnt: (k < 10) ? k : 0, edv: (k == 10), edd: (k == 10) ? 55 : 0,
                   eovf: 1'b0};
    end
    tbl[10] = '{v: 1'b0, x: 7, ea: 0, ecnt: 0, edv: 1'b0, edd: 55, eovf: 1'b0};

    // Reset state
    cycle(0, 1, 9, 0);
    check("reset.a", int'(a10), 0);
    check("reset.dump_valid", int'(dv10), 0);

    // Window of 1..10 on the N=10 instance
    for (int i = 0; i < 11; i++) begin
      cycle(1, tbl[i].v, tbl[i].x, 0);
      check($sformatf("tbl%0d.a", i), int'(a10), tbl[i].ea);
      check($sformatf("tbl%0d.count", i), int'(cnt10), tbl[i].ecnt);
      check($sformatf("tbl%0d.dump_valid", i), int'(dv10), int'(tbl[i].edv));
      check($sformatf("tbl%0d.dump_data", i), int'(dd10), tbl[i].edd);
      check($sformatf("tbl%0d.dump_ovf", i), int'(dovf10), int'(tbl[i].eovf));
    end

    // Subtract below zero from a=0, then finish the window with zero samples
    cycle(1, 1, 3, 1);
    check("sub3.a", int'(a10), SAT ? 0 : 253);
    for (int i = 0; i < 9; i++) cycle(1, 1, 0, 0);
    check("sub3.dump_valid", int'(dv10), 1);
    check("sub3.dump_data", int'(dd10), SAT ? 0 : 253);
    check("sub3.dump_ovf", int'(dovf10), 1);

    // Twenty samples of 15 on the N=20 instance
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 1, 15, 0);
    check("ovf20.dump_valid", int'(dv20), 1);
    check("ovf20.dump_data", int'(dd20), SAT ? 255 : 44);
    check("ovf20.dump_ovf", int'(dovf20), 1);

    // in_valid toggling: only valid edges count
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, (i % 2) == 0, 2, 0);
      if (i == 17) check("toggle.pre_dump", int'(dv10), 0);
      if (i == 18) begin
        check("toggle.dump_valid", int'(dv10), 1);
        check("toggle.dump_data", int'(dd10), 20);
      end
      if (i == 19) check("toggle.dump_fall", int'(dv10), 0);
    end

    // Reset mid-window after five samples
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 3, 0);
    check("midrst.a_before", int'(a10), 15);
    cycle(0, 1, 3, 0);
    check("midrst.a", int'(a10), 0);
    check("midrst.count", int'(cnt10), 0);
    check("midrst.dump_valid", int'(dv10), 0);
    cycle(1, 1, 4, 0);
    check("midrst.restart", int'(a10), 4);

    // Reset coinciding with the tenth sample
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(1, 1, 1, 0);
    cycle(0, 1, 1, 0);
    check("rst10.dump_valid", int'(dv10), 0);
    check("rst10.dump_data", int'(dd10), 0);

    // N=1: every sample dumps, strobe stays high with continuous in_valid
    cycle(1, 1, 5, 0);
    cycle(1, 1, 5, 0);
    check("n1.cont_valid", int'(dv1), 1);
    check("n1.cont_data", int'(dd1), 5);
    check("n1.a_zero", int'(a1), 0);
    cycle(1, 1, 5, 1);
    check("n1.sub_data", int'(dd1), SAT ? 0 : 251);
    check("n1.sub_ovf", int'(dovf1), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 15)), $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
